// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle restoring divider for DIV/DIVU. Sits beside the combinational
//   alu. One quotient bit is resolved per clock, so a division takes WIDTH
//   iterations plus one sign-correction cycle. A start/busy/done handshake
//   lets the control unit stall the pipeline while a division is in flight.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset (aborts any division)
//   start     request, sampled only while idle
//   sign      1 = signed (DIV), 0 = unsigned (DIVU); captured with start
//   dividend  numerator, captured with start
//   divisor   denominator, captured with start
//   q         registered quotient (held until the next result or reset)
//   r         registered remainder (held until the next result or reset)
//   busy      high from the cycle after start up to the sign-correction cycle
//   done      one-cycle pulse when q/r are valid
//   div_zero  set with done when the divisor was zero; held until next start
// ---------------------------------------------------------------------------
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH-1:0] quo;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvsr;      // divisor magnitude
    logic             neg_q;     // negate quotient at FINISH
    logic             neg_r;     // negate remainder at FINISH
    logic             dz_pend;   // captured divisor was zero

    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   trial;
    logic             last_step;

    assign divisor_zero = (divisor == '0);

    // In signed mode the core works on magnitudes. The most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    assign dividend_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Shift the next dividend bit into the remainder and trial-subtract one
    // bit wider than the operands, so divisors >= 2^(WIDTH-1) still compare
    // correctly; trial[WIDTH] is the borrow (negative result).
    assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps every path driven, so no
    // latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = divisor_zero ? FINISH : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        rem      <= '0;
                        dvsr     <= divisor_mag;
                        neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= sign & dividend[WIDTH-1];
                        dz_pend  <= divisor_zero;
                        // A zero divisor skips the loop; keeping the raw
                        // dividend here lets FINISH return it as remainder.
                        quo      <= divisor_zero ? dividend : dividend_mag;
                        div_zero <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (dz_pend) begin
                        q        <= '1;
                        r        <= quo;
                        div_zero <= 1'b1;
                    end else begin
                        q <= neg_q ? -quo : quo;
                        r <= neg_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Self-checking bench for iter_divider: directed corner cases, the busy-
//   start and done-cycle-start handshake cases, an asynchronous abort, then
//   randomized operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_iter_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Last expected q/r, used to check that outputs hold during an operation.
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    iter_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: MIPS DIV/DIVU semantics from plain 64-bit arithmetic.
    function automatic void model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eq, output logic [W-1:0] er);
        longint sa, sb, ma, mb, qq, rr;
        if (b == 0) begin
            eq = '1;
            er = a;
        end else if (!sg) begin
            eq = a / b;
            er = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            qq = ma / mb;
            rr = ma % mb;
            if ((sa < 0) != (sb < 0)) qq = -qq;
            if (sa < 0) rr = -rr;
            eq = qq[W-1:0];
            er = rr[W-1:0];
        end
    endfunction

    // Called at a negedge: presents one start cycle, then scrambles the
    // operand inputs so a late capture would be visible.
    task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        sign     = sg;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        sign     = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Entered at the negedge after the accepting edge. Counts edges until done
    // and the cycles with busy high. Optionally fires a start at cycle 10.
    task automatic wait_done(input bit interfere, output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (!done && edges < 60) begin
            if (busy) busy_n++;
            if (interfere && edges == 9) begin
                start    = 1'b1;
                sign     = 1'b0;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else if (interfere && edges == 10) begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_check(input string tag, input logic sg, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic edz, input bit interfere);
        int edges;
        int busy_n;
        int exp_edges;
        exp_edges = (b == 0) ? 1 : 33;
        launch(sg, a, b);
        chk({tag, ".hold_q"}, q, prev_q);
        chk({tag, ".hold_r"}, r, prev_r);
        chk({tag, ".dz_clr"}, W'(div_zero), W'(0));
        wait_done(interfere, edges, busy_n);
        chk({tag, ".done"}, W'(done), W'(1));
        chk({tag, ".latency"}, W'(edges), W'(exp_edges));
        chk({tag, ".busy_cycles"}, W'(busy_n), W'(exp_edges));
        chk({tag, ".busy_at_done"}, W'(busy), W'(0));
        chk({tag, ".q"}, q, eq);
        chk({tag, ".r"}, r, er);
        chk({tag, ".div_zero"}, W'(div_zero), W'(edz));
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         sg;
        int           seen;

        rst      = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset.q", q, 32'h0);
        chk("reset.r", r, 32'h0);
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.done", W'(done), W'(0));
        chk("reset.div_zero", W'(div_zero), W'(0));
        rst = 1'b0;
        @(negedge clk);

        run_check("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        run_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_check("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        run_check("divu_max_msb", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_check("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run_check("divu_by_zero", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
        run_check("divu_10_3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0);
        run_check("div_by_zero_s", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        @(negedge clk);
        run_check("start_while_busy", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        // Issued in the done cycle of the previous operation.
        run_check("start_in_done", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b0);

        // Asynchronous abort mid-division.
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.q", q, 32'h0);
        chk("abort.r", r, 32'h0);
        chk("abort.busy", W'(busy), W'(0));
        chk("abort.done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b0;
        prev_q = '0;
        prev_r = '0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort.no_done", W'(seen), W'(0));
        run_check("after_abort", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            model(sg, a, b, eq, er);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_check($sformatf("rand%0d", i), sg, a, b, eq, er, (b == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle iterative restoring divider for DIV/DIVU in the MIPS datapath; sits beside the combinational alu.
- Takes a dividend and divisor, produces quotient and remainder after a fixed latency.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while a division runs.
- Shares the alu flag convention: a separate status output for the exceptional case (divide-by-zero).

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when q/r are valid.
- div_zero  output  1  high with done when divisor was 0; holds until the next accepted start.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; q=0, r=0, busy=0, done=0, div_zero=0.
  - Internal shift/accumulator registers are cleared.
  - Reset mid-operation aborts the division; no done pulse is produced.
- States:
  - IDLE: start=1 at edge E0 captures operands and sign, clears div_zero.
    - Divisor==0: next state FINISH.
    - Otherwise: next state RUN, iteration counter=0.
  - RUN: one restoring step per cycle, WIDTH cycles (edges E1..E32).
    - Shift the {rem,quo} pair left by 1.
    - Trial-subtract the divisor magnitude from rem (WIDTH+1-bit subtract).
    - If non-negative: keep the difference and set quo[0]=1; else restore.
    - After the step at counter==WIDTH-1, go to FINISH.
  - FINISH (1 cycle, edge E33): apply sign correction, register q/r, done=1 for the following cycle, next state IDLE.
- busy:
  - 1 from the cycle after E0 up to and including the FINISH cycle.
  - 0 in the cycle where done=1.
- Latency: done is high in the cycle after E33, i.e. 33 edges after start is sampled. For divisor==0, done is high after E1 (2-cycle latency).
- Signed mode:
  - Operate on magnitudes |dividend| and |divisor|.
  - Quotient negated iff dividend[31]^divisor[31]; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0 (wraps naturally, no overflow flag).
- Unsigned mode: no sign handling; 33-bit internal subtract so divisor ≥ 2^31 works.
- Divide by zero (either mode): q=0xFFFFFFFF, r=dividend (as captured), div_zero=1 with done.
- start while busy: ignored; operands are not re-captured, and the in-flight result is unaffected.
- start in the same cycle as done: accepted, because the FSM is already IDLE in that cycle. q/r/div_zero hold the previous result until the new FINISH; div_zero is cleared at the accepting edge.
- q/r hold their values between operations; they change only at FINISH or reset.
- Inputs need only be valid in the start cycle; later changes have no effect.

Test Plan:
- DIVU 100 / 7 (start 1 cycle) -> busy high 33 cycles; done pulse 33 edges after start; q=14, r=2, div_zero=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE (-2) -> q=0xFFFFFFFD, r=1.
- DIVU 0xFFFFFFFF / 0x80000000 -> q=1, r=0x7FFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- Divide by zero, DIVU 1234 / 0 -> done 2 cycles after start; q=0xFFFFFFFF, r=1234, div_zero=1. The next start of 10/3 clears div_zero; result q=3, r=1.
- Start 100/7; at cycle 10 assert start with 50/5 and change the operand inputs -> ignored; result q=14, r=2. Start asserted in the done cycle with 9/2 -> accepted; q=4, r=1 after a further 33 edges.
- Start 100/7; assert rst asynchronously (mid-cycle) at cycle 15 -> q=0, r=0, busy=0 immediately; no done pulse. After release, 20/6 -> q=3, r=2.
